// File: rtl/serial_adder_n.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice plus a carry flop walks the
// operands LSB-first, WIDTH/DIGIT steps per operation, under start/busy/done.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = DIGIT + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_n: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cff_q, cff_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             carry_q, carry_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [DW-1:0]    slice;

    always_comb begin
        slice   = {1'b0, sa_q[DIGIT-1:0]} + {1'b0, sb_q[DIGIT-1:0]} + DW'(cff_q);
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        cff_d   = cff_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            RUN: begin
                sa_d  = sa_q >> DIGIT;
                sb_d  = sb_q >> DIGIT;
                // new digit enters at the top; after N steps SR holds the full result
                sr_d  = (sr_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
                cff_d = slice[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = sr_d;
                    carry_d = slice[DIGIT];
                    ovf_d   = (a_msb_q == b_msb_q) && (sr_d[WIDTH-1] != a_msb_q);
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    // subtraction as A + ~B + 1: the +1 rides in on the carry flop
                    state_d = RUN;
                    sa_d    = a;
                    sb_d    = sub ? ~b : b;
                    cff_d   = sub;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                end
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            cff_q   <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            cff_q   <= cff_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench: drivers push expected results (with due cycle) into per-config
// queues; monitors pop and compare on each done pulse.
module tb_serial_adder_n;
    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        v;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   ndone = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input int av, input int bv, input bit s);
        exp_t e;
        int lim, sa, sb, r;
        lim   = 1 << (w - 1);
        sa    = (av >= lim) ? av - 2 * lim : av;
        sb    = (bv >= lim) ? bv - 2 * lim : bv;
        r     = s ? sa - sb : sa + sb;
        e.v   = (r >= lim) || (r < -lim);
        e.c   = s ? (av >= bv) : (av + bv >= 2 * lim);
        e.sum = 16'((s ? av - bv : av + bv) & (2 * lim - 1));
        e.due = 0;
        return e;
    endfunction

    function automatic int cfg_w(input int g);
        return (g < 2) ? 8 : 16;
    endfunction

    function automatic int cfg_d(input int g);
        return (g == 0) ? 1 : (g == 1) ? 4 : (1 << (g - 2));
    endfunction

    for (genvar g = 0; g < 7; g++) begin : g_cfg
        localparam int W = cfg_w(g);
        localparam int D = cfg_d(g);
        localparam int N = W / D;

        logic         rst = 1'b1, start = 1'b0, sub = 1'b0;
        logic [W-1:0] a = '0, b = '0, sum;
        logic         carry, ovf, busy, done;
        exp_t         q[$];

        serial_adder_n #(.WIDTH(W), .DIGIT(D)) dut (
            .clk(clk), .reset_p(rst), .start(start), .sub(sub), .a(a), .b(b),
            .sum(sum), .carry(carry), .overflow(ovf), .busy(busy), .done(done)
        );

        initial forever begin
            @(negedge clk);
            if (done) begin
                chk($sformatf("cfg%0d_done_expected", g), 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("cfg%0d_sum", g), 32'(sum), 32'(e.sum));
                    chk($sformatf("cfg%0d_carry", g), 32'(carry), 32'(e.c));
                    chk($sformatf("cfg%0d_overflow", g), 32'(ovf), 32'(e.v));
                    chk($sformatf("cfg%0d_latency", g), cyc, e.due);
                    chk($sformatf("cfg%0d_busy_at_done", g), 32'(busy), 0);
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                chk($sformatf("cfg%0d_done_missing", g), cyc, q[0].due);
                void'(q.pop_front());
            end
        end

        task automatic do_reset();
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            chk($sformatf("cfg%0d_reset", g), 32'({sum, carry, ovf, busy, done}), 0);
        endtask

        // Issue at a negedge while the DUT is ready; returns at the DONE cycle.
        task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                              input logic [W-1:0] es, input logic ec, input logic ev,
                              input bit junk);
            exp_t e;
            bit   bok;
            start = 1'b1; a = aa; b = bb; sub = s;
            e.sum = 16'(es); e.c = ec; e.v = ev; e.due = cyc + 1 + N;
            q.push_back(e);
            @(negedge clk);
            bok = 1'b1;
            for (int i = 0; i < N; i++) begin
                bok   = bok & busy & ~done;
                start = junk ? 1'($urandom) : 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom);
                @(negedge clk);
            end
            chk($sformatf("cfg%0d_busy_window", g), 32'({bok, busy}), 2);
            start = 1'b0;
        endtask

        task automatic rnd_op(input bit junk);
            logic [W-1:0] aa, bb;
            logic         s;
            exp_t         e;
            aa = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            bb = ($urandom_range(0, 7) == 0) ? W'(1) : W'($urandom);
            s  = 1'($urandom);
            e  = model(W, int'(aa), int'(bb), s);
            run_op(aa, bb, s, W'(e.sum), e.c, e.v, junk);
        endtask

        if (g == 0) begin : g_dir8
            initial begin
                do_reset();
                run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
                @(negedge clk);
                run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
                run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
                @(negedge clk);
                run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
                run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
                // abort in the fourth RUN cycle: no done, outputs cleared
                start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
                @(negedge clk);
                start = 1'b0;
                repeat (3) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("cfg0_abort_outputs", 32'({sum, carry, ovf, busy, done}), 0);
                repeat (N + 2) @(negedge clk);
                chk("cfg0_abort_idle", 32'({busy, done}), 0);
                run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    rnd_op(1'b1);
                end
                repeat (3) @(negedge clk);
                chk("cfg0_drained", q.size(), 0);
                ndone++;
            end
        end else if (g == 1) begin : g_dir8d4
            initial begin
                do_reset();
                run_op(8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                // start held high: one op per N+1 clocks, busy low only in DONE
                for (int i = 0; i < 20; i++) rnd_op(1'b0);
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    rnd_op(1'b1);
                end
                repeat (3) @(negedge clk);
                chk("cfg1_drained", q.size(), 0);
                ndone++;
            end
        end else begin : g_rand16
            initial begin
                do_reset();
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    rnd_op(1'b1);
                end
                repeat (3) @(negedge clk);
                chk($sformatf("cfg%0d_drained", g), q.size(), 0);
                ndone++;
            end
        end
    end

    initial begin
        for (int t = 0; t < 90000 && ndone < 7; t++) @(negedge clk);
        chk("all_configs_finished", ndone, 7);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised multi-cycle adder/subtractor for the exam series, the sequential successor to the single-bit half adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using one DIGIT-bit adder slice and a carry flip-flop, under a start/busy/done handshake. It sits between operand registers and a result display/FND driver where area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits (≥2).
- DIGIT, 1, bits processed per clock. WIDTH % DIGIT must be 0; otherwise elaboration fails via a generate-time error.
- clk  in  1  single system clock; all logic on the rising edge.
- reset_p  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is ready (IDLE or DONE).
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- a  in  WIDTH  operand A (unsigned or two's complement); sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- sum  out  WIDTH  result; updates only on completion.
- carry  out  1  carry out of MSB. In sub mode, 1 = no borrow (A ≥ B unsigned).
- overflow  out  1  two's-complement signed overflow of the operation.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when sum/carry/overflow are updated.

## Operation
- N = WIDTH/DIGIT digit steps per operation. Digit counter width is clog2(N), min 1.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a into shift reg SA; latch b (or ~b if sub) into SB; carry_ff ← sub; cnt ← 0; go RUN.
  - RUN: each clock adds the low DIGIT bits of SA, SB and carry_ff, then right-shifts SA/SB by DIGIT. The digit sum shifts into the top of the internal result reg SR. carry_ff ← slice carry; cnt++.
  - RUN, cnt = N−1: perform the final step and go DONE. sum ← the complete SR value, including this step's digit. carry ← slice carry. overflow ← (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted b and the MSBs are the latched originals.
  - DONE: done=1 for this one cycle. start=1 → behave as IDLE acceptance (back-to-back) and go RUN. Otherwise go IDLE.
- start, sub, a and b are ignored in RUN. A start pulse during busy is dropped and not queued.
- sum, carry and overflow hold their last result through IDLE and through the next RUN until the next completion.
- Arithmetic is modulo 2^WIDTH. The internal slice is DIGIT+1 bits wide, and its MSB is the carry.

## Timing
- Reset (reset_p=1 at an edge): state IDLE; sum=0, carry=0, overflow=0, busy=0, done=0; SA/SB/SR/carry_ff/cnt cleared.
- Reset has priority over everything, including mid-RUN and DONE. It aborts the operation with no done pulse, and the outputs return to 0.
- Start sampled at edge E0: busy=1 from E0 through edge E_N.
- At edge E_N: sum/carry/overflow are valid, done=1 and busy=0 for the cycle after E_N.
- Latency is N clocks from the accepting edge to valid results.
- Back-to-back: start=1 during the DONE cycle is accepted at E_N+1. busy is then high again after E_N+1, so busy is low for exactly one cycle (the DONE cycle).
- Throughput: one operation every N+1 clocks.
- done and busy are never high simultaneously.
- N=1 (DIGIT=WIDTH): RUN lasts one cycle, and the latency is 1.

## Test plan
- WIDTH=8, DIGIT=1, a=0x35, b=0x4A, sub=0, start one cycle -> busy high for 8 cycles; then done pulse with sum=0x7F, carry=0, overflow=0.
- WIDTH=8, DIGIT=1: 0xFF+0x01 -> sum=0x00, carry=1, overflow=0. 0x7F+0x01 -> sum=0x80, carry=0, overflow=1.
- WIDTH=8, DIGIT=1, sub=1: 0x10−0x20 -> sum=0xF0, carry=0, overflow=0. 0x80−0x01 -> sum=0x7F, carry=1, overflow=1.
- WIDTH=8, DIGIT=4: 0xA5+0x5B -> done exactly 2 cycles after the accepting edge, sum=0x00, carry=1. Then start held high continuously -> one operation per 3 clocks, with a single-cycle busy gap.
- During RUN, pulse start with different a/b -> ignored, and the original result is delivered. Assert reset_p in RUN cycle 4 -> no done, all outputs 0, state IDLE; a following start completes normally.
- Random regression, WIDTH=16 with DIGIT ∈ {1,2,4,8,16}, 1000 ops each -> sum/carry/overflow match the reference model {carry,sum} = a ± b and the signed overflow rule.
